// File: rtl/tile_pixel_renderer.sv
// Tile-map pixel renderer: turns VGA counters into 12-bit RGB from a tile RAM lookup
// plus a player box overlay, with syncs re-timed to match the 3-clk colour pipeline.
//
// state | meaning
// IDLE  | waiting for hCount to change
// ADDR  | drive tile RAM address for the latched pixel
// WAIT  | tile RAM access cycle
// COLOR | register rgb together with the delayed syncs
module tile_pixel_renderer #(
  parameter int unsigned H_ACT_START  = 144,
  parameter int unsigned V_ACT_START  = 35,
  parameter int unsigned H_ACT_LEN    = 640,
  parameter int unsigned V_ACT_LEN    = 480,
  parameter int unsigned MAP_COLS     = 20,
  parameter logic [11:0] PLAYER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  output logic [8:0]  tile_addr,
  input  logic [2:0]  tile_data,
  output logic [11:0] rgb,
  output logic        hSync_out,
  output logic        vSync_out,
  output logic        frame_tick
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, COLOR} state_t;

  state_t      state_q, state_d;
  logic [9:0]  hcount_prev_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        active_q, active_d;
  logic        hsync_lat_q, hsync_lat_d, vsync_lat_q, vsync_lat_d;
  logic [8:0]  tile_addr_q, tile_addr_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_out_q, hsync_out_d, vsync_out_q, vsync_out_d;
  logic        frame_tick_q, frame_tick_d;

  logic        pix_evt;
  logic [10:0] x_s, y_s;
  logic [8:0]  row9, col9, row_base;
  logic [10:0] px11, py11;
  logic        player_hit;
  logic [11:0] tile_color;

  always_comb begin
    pix_evt = (hCount != hcount_prev_q);
    // Signed 11-bit offsets: pixels left of / above the active area go negative.
    x_s = {1'b0, hCount} - 11'(H_ACT_START);
    y_s = {1'b0, vCount} - 11'(V_ACT_START);

    row9 = {4'b0, y_q[9:5]};
    col9 = {4'b0, x_q[9:5]};
    row_base = (MAP_COLS == 20) ? ((row9 << 4) + (row9 << 2)) : (row9 * 9'(MAP_COLS));

    px11 = {1'b0, player_x};
    py11 = {1'b0, player_y};
    player_hit = (x_q >= px11) && (x_q <= px11 + 11'd31) &&
                 (y_q >= py11) && (y_q <= py11 + 11'd31);

    case (tile_data)
      3'd0:    tile_color = 12'h0A0;
      3'd1:    tile_color = 12'h888;
      3'd2:    tile_color = 12'h840;
      3'd3:    tile_color = 12'h222;
      3'd4:    tile_color = 12'hF80;
      default: tile_color = 12'hF0F;
    endcase

    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    active_d     = active_q;
    hsync_lat_d  = hsync_lat_q;
    vsync_lat_d  = vsync_lat_q;
    tile_addr_d  = tile_addr_q;
    rgb_d        = rgb_q;
    hsync_out_d  = hsync_out_q;
    vsync_out_d  = vsync_out_q;
    frame_tick_d = 1'b0;

    if (pix_evt) begin
      // Latest sample wins: any in-flight pixel is dropped.
      state_d      = ADDR;
      x_d          = x_s;
      y_d          = y_s;
      active_d     = !x_s[10] && (x_s < 11'(H_ACT_LEN)) && !y_s[10] && (y_s < 11'(V_ACT_LEN));
      hsync_lat_d  = hSync;
      vsync_lat_d  = vSync;
      frame_tick_d = (hCount == 10'd0) && (vCount == 10'd0);
    end else begin
      case (state_q)
        ADDR: begin
          if (active_q) tile_addr_d = row_base + col9;
          state_d = WAIT;
        end
        WAIT:  state_d = COLOR;
        COLOR: begin
          if (!active_q)       rgb_d = 12'h000;
          else if (player_hit) rgb_d = PLAYER_COLOR;
          else                 rgb_d = tile_color;
          hsync_out_d = hsync_lat_q;
          vsync_out_d = vsync_lat_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hcount_prev_q <= 10'h3FF;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      hsync_lat_q   <= 1'b1;
      vsync_lat_q   <= 1'b1;
      tile_addr_q   <= '0;
      rgb_q         <= '0;
      hsync_out_q   <= 1'b1;
      vsync_out_q   <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_prev_q <= hCount;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_lat_q   <= hsync_lat_d;
      vsync_lat_q   <= vsync_lat_d;
      tile_addr_q   <= tile_addr_d;
      rgb_q         <= rgb_d;
      hsync_out_q   <= hsync_out_d;
      vsync_out_q   <= vsync_out_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign tile_addr  = tile_addr_q;
  assign rgb        = rgb_q;
  assign hSync_out  = hsync_out_q;
  assign vSync_out  = vsync_out_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Directed bench for tile_pixel_renderer: hand-computed colours, addresses, sync delay,
// frame tick, abort behaviour and asynchronous reset.
module tb_tile_pixel_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hCount, vCount, player_x, player_y;
  logic        hSync, vSync;
  logic [8:0]  tile_addr;
  logic [2:0]  tile_data;
  logic [11:0] rgb;
  logic        hSync_out, vSync_out, frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  tile_pixel_renderer dut (
    .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
    .hSync(hSync), .vSync(vSync), .player_x(player_x), .player_y(player_y),
    .tile_addr(tile_addr), .tile_data(tile_data), .rgb(rgb),
    .hSync_out(hSync_out), .vSync_out(vSync_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    hCount = 10'd143; vCount = 10'd35;
    hSync = 1'b1; vSync = 1'b1;
    player_x = 10'd630; player_y = 10'd0;
    tile_data = 3'd1;
    step(2);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_addr", 12'(tile_addr), 12'd0);
    chk("rst_hs", 12'(hSync_out), 12'd1);
    chk("rst_vs", 12'(vSync_out), 12'd1);
    chk("rst_tick", 12'(frame_tick), 12'd0);
    reset = 1'b0;
    step(5);
    chk("pre_left_rgb", rgb, 12'h000);
    chk("no_tick_after_rst", 12'(frame_tick), 12'd0);

    // First visible pixel, tile 1
    hCount = 10'd144;
    step(1); chk("first_tick", 12'(frame_tick), 12'd0);
    step(1); chk("first_addr", 12'(tile_addr), 12'd0);
    step(1); chk("first_rgb_early", rgb, 12'h000);
    step(1); chk("first_rgb", rgb, 12'h888);

    // Last visible pixel, tile 2
    hCount = 10'd783; vCount = 10'd514; tile_data = 3'd2;
    step(2); chk("last_addr", 12'(tile_addr), 12'd299);
    step(2); chk("last_rgb", rgb, 12'h840);

    // Inactive pixel, sync delay
    hCount = 10'd100; vCount = 10'd50; tile_data = 3'd4; hSync = 1'b0; vSync = 1'b1;
    step(2); chk("inact_addr_hold", 12'(tile_addr), 12'd299);
    step(1); chk("inact_hs_early", 12'(hSync_out), 12'd1);
    step(1);
    chk("inact_rgb", rgb, 12'h000);
    chk("inact_hs", 12'(hSync_out), 12'd0);
    chk("inact_vs", 12'(vSync_out), 12'd1);

    // Player box at (630,0)
    hSync = 1'b1;
    hCount = 10'd783; vCount = 10'd66; tile_data = 3'd0;
    step(4); chk("player_hit", rgb, 12'hFFF);
    hCount = 10'd773;
    step(4); chk("player_left_miss", rgb, 12'h0A0);
    hCount = 10'd783; vCount = 10'd67; tile_data = 3'd5;
    step(4); chk("player_below_miss", rgb, 12'hF0F);
    hCount = 10'd144; vCount = 10'd35; tile_data = 3'd3;
    step(4); chk("player_no_wrap", rgb, 12'h222);

    // Counter wrap and frame tick
    hCount = 10'd799; vCount = 10'd524;
    step(1); chk("wrap_pre_tick", 12'(frame_tick), 12'd0);
    step(3);
    hCount = 10'd0; vCount = 10'd0;
    step(1); chk("wrap_tick", 12'(frame_tick), 12'd1);
    step(1); chk("wrap_tick_end", 12'(frame_tick), 12'd0);
    step(2); chk("wrap_rgb", rgb, 12'h000);

    // Abort: second event 2 clk after the first
    hSync = 1'b0; vSync = 1'b0;
    hCount = 10'd783; vCount = 10'd40; tile_data = 3'd4;
    step(2);
    hCount = 10'd300; vCount = 10'd100;
    step(2);
    chk("abort_no_first", rgb, 12'h000);
    chk("abort_addr", 12'(tile_addr), 12'd44);
    step(1); chk("abort_early", rgb, 12'h000);
    step(1); chk("abort_second", rgb, 12'hF80);
    chk("abort_hs", 12'(hSync_out), 12'd0);

    // Async reset with FSM in WAIT
    hCount = 10'd200; vCount = 10'd100; tile_data = 3'd1;
    step(2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rgb", rgb, 12'h000);
    chk("mid_rst_hs", 12'(hSync_out), 12'd1);
    chk("mid_rst_vs", 12'(vSync_out), 12'd1);
    chk("mid_rst_tick", 12'(frame_tick), 12'd0);
    chk("mid_rst_addr", 12'(tile_addr), 12'd0);
    step(1);
    reset = 1'b0;
    step(2); chk("post_rst_addr", 12'(tile_addr), 12'd41);
    step(2);
    chk("post_rst_rgb", rgb, 12'h888);
    chk("post_rst_hs", 12'(hSync_out), 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
